mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store sequencer that sits directly upstream of the 16-bit word-wide data memory.
- Accepts one load/store request at a time from the MEM pipeline stage and converts byte addresses into word indices.
- Performs range and alignment checks, implements byte stores as read-modify-write, and sign- or zero-extends byte loads.
- Returns a single-cycle response to the pipeline.

Parameters:
- DEPTH, 128, number of 16-bit words in the data memory; word index must be < DEPTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_op  input  3  000 LW, 001 LB (sign-ext), 010 LBU (zero-ext), 100 SW, 101 SB; others illegal
- req_addr  input  16  byte address
- req_wdata  input  16  store data (SB uses bits [7:0])
- resp_valid  output  1  one-cycle pulse: request complete
- resp_data  output  16  load result; 0 for stores and faults
- resp_fault  output  1  qualified by resp_valid: illegal op, misaligned word access, or out-of-range
- mem_addr  output  16  word index to memory (req_addr >> 1, zero-extended)
- mem_write_data  output  16  write data to memory
- mem_write  output  1  memory write strobe
- mem_read  output  1  memory read strobe
- mem_data_out  input  16  memory read data; valid the cycle after a cycle with mem_read=1

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_fault=0, mem_addr=0, mem_write_data=0, mem_write=0, mem_read=0.
- mem_read and mem_write are decoded from the state register only, so reset deasserts them immediately.
- Acceptance: in IDLE, req_valid=1 registers op, addr and wdata. req_valid outside IDLE is ignored.
- Decode at acceptance:
  - Fault if op is illegal.
  - Fault if op is LW/SW and req_addr[0]=1.
  - Fault if req_addr[15:1] >= DEPTH.
- Byte lane is little-endian: addr[0]=0 selects bits [7:0], addr[0]=1 selects bits [15:8].
- States:
  - IDLE: waits for a request.
  - RD: mem_read=1.
  - CAP: samples mem_data_out.
  - WR: mem_write=1.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Transitions:
  - Fault: IDLE -> RESP (resp_fault=1, resp_data=0). No memory strobe is asserted.
  - LW/LB/LBU: IDLE -> RD -> CAP -> RESP. resp_valid asserts 3 cycles after the acceptance edge.
  - SW: IDLE -> WR -> RESP. mem_write_data=wdata; resp_valid 2 cycles after acceptance.
  - SB: IDLE -> RD -> CAP -> WR -> RESP. In CAP, the selected byte of the captured word is replaced by wdata[7:0] and the merged word is written in WR; resp_valid 4 cycles after acceptance.
- Load formatting in CAP:
  - LW returns the full word.
  - LB sign-extends the selected byte.
  - LBU zero-extends the selected byte.
  - The result is registered into resp_data and held until the next RESP.
- mem_addr is loaded at acceptance (also for faulting requests, but no strobe is issued) and held stable through the whole operation.
- Exactly one mem_read and/or one mem_write pulse occurs per request; never both in the same cycle.
- Reset mid-operation: the sequence is aborted and no later write occurs. A write already committed in WR stays committed.
- Throughput: back-to-back requests are accepted one cycle after RESP (IDLE).

Test Plan:
- Memory initialised with word[k]=k. LW addr 0x000A -> mem_read pulse with mem_addr=5; resp_valid 3 cycles after acceptance; resp_data=0x0005, resp_fault=0.
- SW addr 0x0006 data 0x80F0 -> single mem_write at mem_addr=3; resp 2 cycles later, resp_data=0. Then:
  - LB 0x0007 -> 0xFF80.
  - LBU 0x0007 -> 0x0080.
  - LB 0x0006 -> 0xFFF0.
- SB addr 0x0009 data 0x12AB on word 4 (=0x0004) -> read, then write 0xAB04; resp 4 cycles after acceptance. LW 0x0008 -> 0xAB04.
- Fault cases, each giving resp_valid 1 cycle after acceptance, resp_fault=1, resp_data=0, and no mem_read/mem_write:
  - LW addr 0x0003 (misaligned).
  - SW addr 0x0100 (word 128 >= DEPTH).
  - op 011 (illegal).
- Reset asserted during CAP of SB addr 0x0004 -> mem_write never pulses; outputs return to reset values immediately; subsequent LW 0x0004 -> 0x0002.
- req_valid held high continuously with changing addresses -> only requests presented while req_ready=1 are executed; intermediate values ignored; one resp_valid per accepted request.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer in front of a 16-bit word-wide data memory
// Byte stores are read-modify-write; byte loads pick a little-endian lane and extend it.
module mem_access_unit #(
   parameter int DEPTH = 128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        resp_valid,
   output logic [15:0] resp_data,
   output logic        resp_fault,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_write_data,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [15:0] mem_data_out
);

   localparam logic [2:0] OP_LW  = 3'b000;
   localparam logic [2:0] OP_LB  = 3'b001;
   localparam logic [2:0] OP_LBU = 3'b010;
   localparam logic [2:0] OP_SW  = 3'b100;
   localparam logic [2:0] OP_SB  = 3'b101;

   typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RESP} state_t;

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic        lane_q, lane_d;
   logic [7:0]  wbyte_q, wbyte_d;
   logic        fault_q, fault_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_wdata_q, mem_wdata_d;
   logic [15:0] resp_data_q, resp_data_d;

   logic        op_legal;
   logic        req_fault;
   logic [7:0]  cap_byte;

   always_comb begin
      op_legal  = (req_op == OP_LW) || (req_op == OP_LB) || (req_op == OP_LBU) ||
                  (req_op == OP_SW) || (req_op == OP_SB);
      req_fault = !op_legal ||
                  (((req_op == OP_LW) || (req_op == OP_SW)) && req_addr[0]) ||
                  (32'(req_addr[15:1]) >= 32'(DEPTH));
      cap_byte  = lane_q ? mem_data_out[15:8] : mem_data_out[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (req_fault)             state_d = S_RESP;
               else if (req_op == OP_SW)  state_d = S_WR;
               else                       state_d = S_RD;
            end
         end
         S_RD:    state_d = S_CAP;
         S_CAP:   state_d = (op_q == OP_SB) ? S_WR : S_RESP;
         S_WR:    state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready      = (state_q == S_IDLE);
      resp_valid     = (state_q == S_RESP);
      mem_read       = (state_q == S_RD);
      mem_write      = (state_q == S_WR);
      resp_fault     = (state_q == S_RESP) && fault_q;
      resp_data      = resp_data_q;
      mem_addr       = mem_addr_q;
      mem_write_data = mem_wdata_q;
   end

   // Request capture, load formatting and the SB merge all happen here.
   always_comb begin
      op_d        = op_q;
      lane_d      = lane_q;
      wbyte_d     = wbyte_q;
      fault_d     = fault_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      resp_data_d = resp_data_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d       = req_op;
               lane_d     = req_addr[0];
               wbyte_d    = req_wdata[7:0];
               fault_d    = req_fault;
               mem_addr_d = {1'b0, req_addr[15:1]};
               if (!req_fault && (req_op == OP_SW)) mem_wdata_d = req_wdata;
               if (req_fault) resp_data_d = 16'h0000;
            end
         end
         S_CAP: begin
            if (op_q == OP_SB) begin
               mem_wdata_d = lane_q ? {wbyte_q, mem_data_out[7:0]}
                                    : {mem_data_out[15:8], wbyte_q};
            end else if (op_q == OP_LB) begin
               resp_data_d = {{8{cap_byte[7]}}, cap_byte};
            end else if (op_q == OP_LBU) begin
               resp_data_d = {8'h00, cap_byte};
            end else begin
               resp_data_d = mem_data_out;
            end
         end
         S_WR:    resp_data_d = 16'h0000;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q        <= OP_LW;
         lane_q      <= 1'b0;
         wbyte_q     <= 8'h00;
         fault_q     <= 1'b0;
         mem_addr_q  <= 16'h0000;
         mem_wdata_q <= 16'h0000;
         resp_data_q <= 16'h0000;
      end else begin
         op_q        <= op_d;
         lane_q      <= lane_d;
         wbyte_q     <= wbyte_d;
         fault_q     <= fault_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         resp_data_q <= resp_data_d;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'b000;
   logic [15:0] req_addr = 16'h0000;
   logic [15:0] req_wdata = 16'h0000;
   logic        resp_valid;
   logic [15:0] resp_data;
   logic        resp_fault;
   logic [15:0] mem_addr;
   logic [15:0] mem_write_data;
   logic        mem_write;
   logic        mem_read;
   logic [15:0] mem_data_out;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.DEPTH(128)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_write(mem_write), .mem_read(mem_read), .mem_data_out(mem_data_out)
   );

   logic [15:0] tb_mem [0:127];
   logic [15:0] rdata_q = 16'h0000;
   assign mem_data_out = rdata_q;

   initial begin
      for (int k = 0; k < 128; k++) tb_mem[k] = 16'(k);
   end

   always @(posedge clk) begin
      if (mem_write) tb_mem[mem_addr[6:0]] <= mem_write_data;
      if (mem_read)  rdata_q <= tb_mem[mem_addr[6:0]];
   end

   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          both_cnt = 0;
   logic [15:0] rd_addr_l = 16'h0000;
   logic [15:0] wr_addr_l = 16'h0000;
   logic [15:0] wr_data_l = 16'h0000;

   always @(negedge clk) begin
      if (mem_read) begin
         rd_cnt++;
         rd_addr_l = mem_addr;
      end
      if (mem_write) begin
         wr_cnt++;
         wr_addr_l = mem_addr;
         wr_data_l = mem_write_data;
      end
      if (mem_read && mem_write) both_cnt++;
   end

   task automatic issue(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                        output int lat, output logic [15:0] data, output logic fault,
                        output int nrd, output int nwr, output logic [15:0] maddr);
      int rd0, wr0;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
      rd0 = rd_cnt; wr0 = wr_cnt;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = 16'hFFFF; req_wdata = 16'hDEAD;
      maddr = mem_addr;
      lat = 1;
      while (!resp_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!resp_valid) lat = 99;
      data  = resp_data;
      fault = resp_fault;
      nrd   = rd_cnt - rd0;
      nwr   = wr_cnt - wr0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({req_ready, resp_valid, resp_fault, mem_write, mem_read} !== 5'b10000) begin
         failures++;
         $display("FAIL reset_ctrl: got %b expected 10000", {req_ready, resp_valid, resp_fault, mem_write, mem_read});
      end
      checks++;
      if ({resp_data, mem_addr, mem_write_data} !== 48'h0) begin
         failures++;
         $display("FAIL reset_data: got %h expected 0", {resp_data, mem_addr, mem_write_data});
      end
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_load_word();
      int lat, nrd, nwr; logic [15:0] d, ma; logic f;
      issue(3'b000, 16'h000A, 16'h0000, lat, d, f, nrd, nwr, ma);
      checks++; if (lat !== 3) begin failures++; $display("FAIL lw_latency: got %0d expected 3", lat); end
      checks++; if (d !== 16'h0005) begin failures++; $display("FAIL lw_data: got %h expected 0005", d); end
      checks++; if (f !== 1'b0) begin failures++; $display("FAIL lw_fault: got %b expected 0", f); end
      checks++; if (nrd !== 1 || nwr !== 0) begin failures++; $display("FAIL lw_strobes: got rd=%0d wr=%0d expected rd=1 wr=0", nrd, nwr); end
      checks++; if (rd_addr_l !== 16'h0005 || ma !== 16'h0005) begin failures++; $display("FAIL lw_addr: got %h/%h expected 0005", rd_addr_l, ma); end
      issue(3'b000, 16'h00FE, 16'h0000, lat, d, f, nrd, nwr, ma);
      checks++; if (d !== 16'h007F || f !== 1'b0) begin failures++; $display("FAIL lw_last_word: got %h f=%b expected 007f f=0", d, f); end
   endtask

   task automatic test_store_word();
      int lat, nrd, nwr; logic [15:0] d, ma; logic f;
      logic [2:0]  ops [3] = '{3'b001, 3'b010, 3'b001};
      logic [15:0] adr [3] = '{16'h0007, 16'h0007, 16'h0006};
      logic [15:0] exp [3] = '{16'hFF80, 16'h0080, 16'hFFF0};
      issue(3'b100, 16'h0006, 16'h80F0, lat, d, f, nrd, nwr, ma);
      checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency: got %0d expected 2", lat); end
      checks++; if (d !== 16'h0000 || f !== 1'b0) begin failures++; $display("FAIL sw_resp: got %h f=%b expected 0000 f=0", d, f); end
      checks++; if (nrd !== 0 || nwr !== 1) begin failures++; $display("FAIL sw_strobes: got rd=%0d wr=%0d expected rd=0 wr=1", nrd, nwr); end
      checks++; if (wr_addr_l !== 16'h0003 || wr_data_l !== 16'h80F0) begin failures++; $display("FAIL sw_write: got %h@%h expected 80f0@0003", wr_data_l, wr_addr_l); end
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], adr[i], 16'h0000, lat, d, f, nrd, nwr, ma);
         checks++;
         if (d !== exp[i] || f !== 1'b0 || lat !== 3) begin
            failures++;
            $display("FAIL byte_load_%0d: got %h f=%b lat=%0d expected %h f=0 lat=3", i, d, f, lat, exp[i]);
         end
      end
   endtask

   task automatic test_store_byte();
      int lat, nrd, nwr; logic [15:0] d, ma; logic f;
      issue(3'b101, 16'h0009, 16'h12AB, lat, d, f, nrd, nwr, ma);
      checks++; if (lat !== 4) begin failures++; $display("FAIL sb_latency: got %0d expected 4", lat); end
      checks++; if (nrd !== 1 || nwr !== 1) begin failures++; $display("FAIL sb_strobes: got rd=%0d wr=%0d expected rd=1 wr=1", nrd, nwr); end
      checks++; if (wr_addr_l !== 16'h0004 || wr_data_l !== 16'hAB04) begin failures++; $display("FAIL sb_merge: got %h@%h expected ab04@0004", wr_data_l, wr_addr_l); end
      checks++; if (d !== 16'h0000 || f !== 1'b0) begin failures++; $display("FAIL sb_resp: got %h f=%b expected 0000 f=0", d, f); end
      issue(3'b000, 16'h0008, 16'h0000, lat, d, f, nrd, nwr, ma);
      checks++; if (d !== 16'hAB04) begin failures++; $display("FAIL sb_readback: got %h expected ab04", d); end
   endtask

   task automatic test_faults();
      int lat, nrd, nwr; logic [15:0] d, ma; logic f;
      logic [2:0]  ops [3] = '{3'b000, 3'b100, 3'b011};
      logic [15:0] adr [3] = '{16'h0003, 16'h0100, 16'h0002};
      logic [15:0] ema [3] = '{16'h0001, 16'h0080, 16'h0001};
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], adr[i], 16'h5555, lat, d, f, nrd, nwr, ma);
         checks++;
         if (lat !== 1 || f !== 1'b1 || d !== 16'h0000) begin
            failures++;
            $display("FAIL fault_resp_%0d: got lat=%0d f=%b d=%h expected lat=1 f=1 d=0000", i, lat, f, d);
         end
         checks++;
         if (nrd !== 0 || nwr !== 0 || ma !== ema[i]) begin
            failures++;
            $display("FAIL fault_mem_%0d: got rd=%0d wr=%0d addr=%h expected rd=0 wr=0 addr=%h", i, nrd, nwr, ma, ema[i]);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      int lat, nrd, nwr, wr0; logic [15:0] d, ma; logic f;
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'b101; req_addr = 16'h0004; req_wdata = 16'h0055;
      wr0 = wr_cnt;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      checks++;
      if ({req_ready, resp_valid, resp_fault, mem_write, mem_read} !== 5'b10000) begin
         failures++;
         $display("FAIL midreset_ctrl: got %b expected 10000", {req_ready, resp_valid, resp_fault, mem_write, mem_read});
      end
      checks++;
      if ({resp_data, mem_addr, mem_write_data} !== 48'h0) begin
         failures++;
         $display("FAIL midreset_data: got %h expected 0", {resp_data, mem_addr, mem_write_data});
      end
      repeat (3) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      checks++; if (wr_cnt !== wr0) begin failures++; $display("FAIL midreset_nowrite: got %0d writes expected 0", wr_cnt - wr0); end
      issue(3'b000, 16'h0004, 16'h0000, lat, d, f, nrd, nwr, ma);
      checks++; if (d !== 16'h0002 || f !== 1'b0) begin failures++; $display("FAIL midreset_readback: got %h expected 0002", d); end
   endtask

   task automatic test_back_to_back();
      int rd0, nresp;
      rd0 = rd_cnt; nresp = 0;
      for (int j = 0; j <= 12; j++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== ((j % 4) == 0)) begin
            failures++;
            $display("FAIL b2b_ready_%0d: got %b expected %b", j, req_ready, (j % 4) == 0);
         end
         checks++;
         if (resp_valid !== ((j % 4) == 3)) begin
            failures++;
            $display("FAIL b2b_valid_%0d: got %b expected %b", j, resp_valid, (j % 4) == 3);
         end
         if ((j % 4) == 3) begin
            nresp++;
            checks++;
            if (resp_data !== 16'(20 + j - 3)) begin
               failures++;
               $display("FAIL b2b_data_%0d: got %h expected %h", j, resp_data, 16'(20 + j - 3));
            end
         end
         if (j < 12) begin
            req_valid = 1'b1; req_op = 3'b000; req_addr = 16'(2 * (20 + j));
         end else begin
            req_valid = 1'b0;
         end
      end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (rd_cnt - rd0 !== 3 || nresp !== 3) begin failures++; $display("FAIL b2b_count: got %0d reads expected 3", rd_cnt - rd0); end
      checks++; if (both_cnt !== 0) begin failures++; $display("FAIL rd_wr_overlap: got %0d expected 0", both_cnt); end
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_store_word();
      test_store_byte();
      test_faults();
      test_reset_mid_op();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
